// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow pipeline of in-flight destination registers driving
// EX operand forward selects, load-use stall detection and a stall-cycle counter.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W = 16,
    localparam int SELW = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwr_i,
    input  logic              id_memrd_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [SELW-1:0]   fwd_a_o,
    output logic [SELW-1:0]   fwd_b_o,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rsUsed;
        logic              rtUsed;
        logic [REG_AW-1:0] rd;
        logic              regwr;
        logic              memrd;
    } entry_t;

    entry_t            pipe [0:FWD_DEPTH];
    entry_t            idEntry;
    logic [CNT_W-1:0]  stallCnt;

    function automatic logic writes(entry_t e);
        return e.valid && e.regwr && (e.rd != '0);
    endfunction

    assign idEntry = '{valid: id_valid_i, rs: id_rs_i, rt: id_rt_i, rsUsed: id_rs_used_i,
                       rtUsed: id_rt_used_i, rd: id_rd_i, regwr: id_regwr_i, memrd: id_memrd_i};
    assign ex_valid_o  = pipe[0].valid;
    assign stall_cnt_o = stallCnt;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        fwd_a_o = '0;
        fwd_b_o = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (pipe[0].valid && pipe[0].rsUsed && writes(pipe[k]) && pipe[k].rd == pipe[0].rs)
                fwd_a_o = SELW'(k);
            if (pipe[0].valid && pipe[0].rtUsed && writes(pipe[k]) && pipe[k].rd == pipe[0].rt)
                fwd_b_o = SELW'(k);
        end
    end

    always_comb begin
        stall_o = 1'b0;
        for (int k = 0; k <= LOAD_STAGE - 2; k++)
            if (pipe[k].memrd && writes(pipe[k]) &&
                ((id_rs_used_i && pipe[k].rd == id_rs_i) || (id_rt_used_i && pipe[k].rd == id_rt_i)))
                stall_o = 1'b1;
        stall_o = stall_o && id_valid_i && !flush_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k <= FWD_DEPTH; k++) pipe[k] <= '0;
            stallCnt <= '0;
        end else if (!hold_i) begin
            for (int k = FWD_DEPTH; k >= 1; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= (id_valid_i && !stall_o && !flush_i) ? idEntry : '0;
            if (stall_o && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for fwd_hazard_unit in the default build
// and in a deep build (FWD_DEPTH=3, LOAD_STAGE=3, CNT_W=4).
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    logic idValid, idRsUsed, idRtUsed, idRegwr, idMemrd, hold, flush;
    logic [4:0] idRs, idRt, idRd;
    logic stall1, exValid1, stall2, exValid2;
    logic [1:0] fwdA1, fwdB1, fwdA2, fwdB2;
    logic [15:0] cnt1;
    logic [3:0] cnt2;
    logic [21:0] obs1, obs2;
    logic [21:0] sb[$];
    int nChecks = 0;
    int nFails = 0;

    typedef struct packed {
        logic v;
        logic [4:0] rs, rt;
        logic rsU, rtU;
        logic [4:0] rd;
        logic wr, ld, h, f;
    } stim_t;

    always #5 clk = ~clk;

    fwd_hazard_unit dut1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_rs_i(idRs), .id_rt_i(idRt),
        .id_rs_used_i(idRsUsed), .id_rt_used_i(idRtUsed), .id_rd_i(idRd), .id_regwr_i(idRegwr),
        .id_memrd_i(idMemrd), .hold_i(hold), .flush_i(flush), .stall_o(stall1),
        .fwd_a_o(fwdA1), .fwd_b_o(fwdB1), .ex_valid_o(exValid1), .stall_cnt_o(cnt1)
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_STAGE(3), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_rs_i(idRs), .id_rt_i(idRt),
        .id_rs_used_i(idRsUsed), .id_rt_used_i(idRtUsed), .id_rd_i(idRd), .id_regwr_i(idRegwr),
        .id_memrd_i(idMemrd), .hold_i(hold), .flush_i(flush), .stall_o(stall2),
        .fwd_a_o(fwdA2), .fwd_b_o(fwdB2), .ex_valid_o(exValid2), .stall_cnt_o(cnt2)
    );

    // Observed vectors are {stall, fwdA, fwdB, exValid, count[15:0]}.
    assign obs1 = {stall1, fwdA1, fwdB1, exValid1, cnt1};
    assign obs2 = {stall2, fwdA2, fwdB2, exValid2, 12'd0, cnt2};

    function automatic stim_t st(input int v, rs, rt, rsU, rtU, rd, wr, ld, h, f);
        return '{1'(v), 5'(rs), 5'(rt), 1'(rsU), 1'(rtU), 5'(rd), 1'(wr), 1'(ld), 1'(h), 1'(f)};
    endfunction

    function automatic stim_t alu(input int rs, rt, rd);
        return st(1, rs, rt, 1, 1, rd, 1, 0, 0, 0);
    endfunction

    function automatic stim_t ldw(input int rs, rd);
        return st(1, rs, 0, 1, 0, rd, 1, 1, 0, 0);
    endfunction

    function automatic stim_t idl();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [21:0] x(input int s, a, b, v, c);
        return {1'(s), 2'(a), 2'(b), 1'(v), 16'(c)};
    endfunction

    task automatic apply(input stim_t s);
        idValid = s.v; idRs = s.rs; idRt = s.rt; idRsUsed = s.rsU; idRtUsed = s.rtU;
        idRd = s.rd; idRegwr = s.wr; idMemrd = s.ld; hold = s.h; flush = s.f;
    endtask

    task automatic drain();
        repeat (4) begin
            apply(idl());
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [21:0] expd;
        rst = 1'b1;
        apply(alu(5, 5, 5));
        @(negedge clk);
        #1;
        sb.push_back(x(0, 0, 0, 0, 0));
        sb.push_back(x(0, 0, 0, 0, 0));
        expd = sb.pop_front();
        nChecks++;
        if (obs1 !== expd) begin
            nFails++;
            $display("FAIL reset dut1: got %h, expected %h", obs1, expd);
        end
        expd = sb.pop_front();
        nChecks++;
        if (obs2 !== expd) begin
            nFails++;
            $display("FAIL reset dut2: got %h, expected %h", obs2, expd);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [21:0] e[$];
        logic [21:0] expd;
        s = '{alu(1, 2, 3), alu(3, 6, 7), alu(9, 8, 10), alu(7, 7, 11), idl(), idl()};
        e = '{x(0, 0, 0, 0, 0), x(0, 0, 0, 1, 0), x(0, 1, 0, 1, 0), x(0, 0, 0, 1, 0),
              x(0, 2, 2, 1, 0), x(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs1 !== expd) begin
                nFails++;
                $display("FAIL back_to_back cycle %0d: got %h, expected %h", i, obs1, expd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        logic [21:0] e[$];
        logic [21:0] expd;
        s = '{st(1, 0, 0, 0, 0, 4, 1, 0, 0, 0), st(1, 0, 0, 0, 0, 4, 1, 0, 0, 0),
              st(1, 4, 4, 0, 1, 12, 1, 0, 0, 0), st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0),
              st(1, 0, 0, 1, 1, 13, 1, 0, 0, 0), idl(), idl()};
        e = '{x(0, 0, 0, 0, 0), x(0, 0, 0, 1, 0), x(0, 0, 0, 1, 0), x(0, 0, 1, 1, 0),
              x(0, 0, 0, 1, 0), x(0, 0, 0, 1, 0), x(0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs1 !== expd) begin
                nFails++;
                $display("FAIL priority cycle %0d: got %h, expected %h", i, obs1, expd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [21:0] e[$];
        logic [21:0] expd;
        s = '{ldw(1, 5), alu(5, 6, 8), alu(5, 6, 8), idl(), idl()};
        e = '{x(0, 0, 0, 0, 0), x(1, 0, 0, 1, 0), x(0, 0, 0, 0, 1), x(0, 2, 0, 1, 1),
              x(0, 0, 0, 0, 1)};
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs1 !== expd) begin
                nFails++;
                $display("FAIL load_use cycle %0d: got %h, expected %h", i, obs1, expd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_stall();
        stim_t s[$];
        logic [21:0] e[$];
        logic [21:0] expd;
        s = '{ldw(1, 5), st(1, 5, 7, 0, 1, 9, 1, 0, 0, 0), idl(), ldw(1, 5),
              st(1, 5, 7, 1, 1, 9, 1, 0, 0, 1), idl(), idl()};
        e = '{x(0, 0, 0, 0, 1), x(0, 0, 0, 1, 1), x(0, 0, 0, 1, 1), x(0, 0, 0, 0, 1),
              x(0, 0, 0, 1, 1), x(0, 0, 0, 0, 1), x(0, 0, 0, 0, 1)};
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs1 !== expd) begin
                nFails++;
                $display("FAIL no_stall cycle %0d: got %h, expected %h", i, obs1, expd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        stim_t s[$];
        logic [21:0] e[$];
        logic [21:0] expd;
        s = '{alu(1, 2, 3), ldw(3, 5), st(1, 5, 6, 1, 1, 8, 1, 0, 1, 0),
              st(1, 5, 6, 1, 1, 8, 1, 0, 1, 0), st(1, 5, 6, 1, 1, 8, 1, 0, 1, 0),
              alu(5, 6, 8), alu(5, 6, 8), idl()};
        e = '{x(0, 0, 0, 0, 1), x(0, 0, 0, 1, 1), x(1, 1, 0, 1, 1), x(1, 1, 0, 1, 1),
              x(1, 1, 0, 1, 1), x(1, 1, 0, 1, 1), x(0, 0, 0, 0, 2), x(0, 2, 0, 1, 2)};
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs1 !== expd) begin
                nFails++;
                $display("FAIL hold cycle %0d: got %h, expected %h", i, obs1, expd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [21:0] expd;
        apply(ldw(1, 5));
        sb.push_back(x(0, 0, 0, 0, 2));
        #1;
        expd = sb.pop_front();
        nChecks++;
        if (obs1 !== expd) begin
            nFails++;
            $display("FAIL reset_mid_stall load: got %h, expected %h", obs1, expd);
        end
        @(negedge clk);
        apply(alu(5, 6, 8));
        sb.push_back(x(1, 0, 0, 1, 2));
        #1;
        expd = sb.pop_front();
        nChecks++;
        if (obs1 !== expd) begin
            nFails++;
            $display("FAIL reset_mid_stall stall: got %h, expected %h", obs1, expd);
        end
        #2;
        rst = 1'b1;
        sb.push_back(x(0, 0, 0, 0, 0));
        #1;
        expd = sb.pop_front();
        nChecks++;
        if (obs1 !== expd) begin
            nFails++;
            $display("FAIL reset_mid_stall async: got %h, expected %h", obs1, expd);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_deep_stall();
        stim_t s[$];
        logic [21:0] e[$];
        logic [21:0] expd;
        s = '{ldw(1, 5), alu(5, 6, 8), alu(5, 6, 8), alu(5, 6, 8), idl(), idl()};
        e = '{x(0, 0, 0, 0, 0), x(1, 0, 0, 1, 0), x(1, 0, 0, 0, 1), x(0, 0, 0, 0, 2),
              x(0, 3, 0, 1, 2), x(0, 0, 0, 0, 2)};
        foreach (s[i]) begin
            apply(s[i]);
            sb.push_back(e[i]);
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs2 !== expd) begin
                nFails++;
                $display("FAIL deep_stall cycle %0d: got %h, expected %h", i, obs2, expd);
            end
            @(negedge clk);
        end
    endtask

    // A load that reads its own destination stalls 2 of every 3 cycles in the deep
    // build: 24 cycles add 16 stalls to the 2 already counted, past the 4-bit limit.
    task automatic test_saturation();
        logic [21:0] expd;
        repeat (24) begin
            apply(st(1, 5, 0, 1, 0, 5, 1, 1, 0, 0));
            @(negedge clk);
        end
        drain();
        for (int i = 0; i < 2; i++) begin
            apply(idl());
            sb.push_back(x(0, 0, 0, 0, 15));
            #1;
            expd = sb.pop_front();
            nChecks++;
            if (obs2 !== expd) begin
                nFails++;
                $display("FAIL saturation cycle %0d: got %h, expected %h", i, obs2, expd);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        apply(idl());
        test_reset();
        test_back_to_back();
        drain();
        test_priority();
        drain();
        test_load_use();
        drain();
        test_no_stall();
        drain();
        test_hold();
        drain();
        test_reset_mid_stall();
        test_deep_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
